// File: rtl/branch_redirect_ctrl_if.sv
// ============================================================================
// Module      : branch_redirect_ctrl_if
// Description : EX-branch / fetch-redirect signal bundle for the redirect controller
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_redirect_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int STAT_W = 32
);
  logic              br_valid;
  logic [1:0]        br_type;
  logic              zero;
  logic              lt;
  logic [ADDR_W-1:0] br_pc;
  logic [ADDR_W-1:0] br_offset;
  logic              redirect_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              flush_if;
  logic              flush_id;
  logic              stall_ex;
  logic              misalign_err;
  logic [STAT_W-1:0] branch_cnt;
  logic [STAT_W-1:0] taken_cnt;

  // EX decode and fetch side of the pipeline
  modport master (
    output br_valid, br_type, zero, lt, br_pc, br_offset, redirect_ready,
    input  redirect_valid, redirect_pc, flush_if, flush_id, stall_ex,
           misalign_err, branch_cnt, taken_cnt
  );

  modport slave (
    input  br_valid, br_type, zero, lt, br_pc, br_offset, redirect_ready,
    output redirect_valid, redirect_pc, flush_if, flush_id, stall_ex,
           misalign_err, branch_cnt, taken_cnt
  );
endinterface

`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
// ============================================================================
// Module      : branch_redirect_ctrl
// Description : Resolves EX branches, flushes IF/ID once, holds a PC redirect
//               until fetch accepts it. Optional counters: BRANCH_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_redirect_ctrl #(
  parameter int ADDR_W = 32,
  parameter int STAT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_redirect_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] FLUSH    = 2'd1;
  localparam logic [1:0] REDIRECT = 2'd2;

  localparam logic [1:0] T_NO_JUMP = 2'b00;
  localparam logic [1:0] T_BEQ     = 2'b01;
  localparam logic [1:0] T_BLT     = 2'b10;
  localparam logic [1:0] T_JAL     = 2'b11;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
  logic              misalign_err_q, misalign_err_d;
  logic              taken;
  logic [ADDR_W-1:0] target;

  always_comb begin
    taken = 1'b0;
    case (bus.br_type)
      T_BEQ:     taken = bus.zero;
      T_BLT:     taken = bus.lt;
      T_JAL:     taken = 1'b1;
      T_NO_JUMP: taken = 1'b0;
      default:   taken = 1'b0;
    endcase
  end

  // Carry out of the add is dropped so targets wrap modulo 2^ADDR_W
  assign target = bus.br_pc + bus.br_offset;

  always_comb begin
    state_d        = state_q;
    redirect_pc_d  = redirect_pc_q;
    misalign_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.br_valid && taken) begin
          if (target[1:0] == 2'b00) begin
            redirect_pc_d = target;
            state_d       = FLUSH;
          end else begin
            misalign_err_d = 1'b1;
          end
        end
      end
      FLUSH:    state_d = bus.redirect_ready ? IDLE : REDIRECT;
      REDIRECT: if (bus.redirect_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      redirect_pc_q  <= '0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      redirect_pc_q  <= redirect_pc_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  // Control outputs decode the state register only, keeping them input-independent
  assign bus.flush_if       = (state_q == FLUSH);
  assign bus.flush_id       = (state_q == FLUSH);
  assign bus.redirect_valid = (state_q == FLUSH) || (state_q == REDIRECT);
  assign bus.stall_ex       = (state_q == FLUSH) || (state_q == REDIRECT);
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.misalign_err   = misalign_err_q;

`ifdef BRANCH_STATS_EN
  localparam logic [STAT_W-1:0] CNT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [STAT_W-1:0] taken_cnt_q,  taken_cnt_d;

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if ((state_q == IDLE) && bus.br_valid && (bus.br_type != T_NO_JUMP)) begin
      if (!(&branch_cnt_q)) branch_cnt_d = branch_cnt_q + CNT_ONE;
      if (taken && !(&taken_cnt_q)) taken_cnt_d = taken_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign bus.branch_cnt = branch_cnt_q;
  assign bus.taken_cnt  = taken_cnt_q;
`else
  assign bus.branch_cnt = {STAT_W{1'b0}};
  assign bus.taken_cnt  = {STAT_W{1'b0}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl; control outputs checked as
// {flush_if, flush_id, redirect_valid, stall_ex, misalign_err}.
`default_nettype none

module tb_branch_redirect_ctrl;

  localparam logic [1:0] NJ  = 2'b00;
  localparam logic [1:0] BEQ = 2'b01;
  localparam logic [1:0] BLT = 2'b10;
  localparam logic [1:0] JAL = 2'b11;

  localparam logic [4:0] C_IDLE = 5'b00000;
  localparam logic [4:0] C_FL   = 5'b11110;
  localparam logic [4:0] C_RD   = 5'b00110;
  localparam logic [4:0] C_MIS  = 5'b00001;

`ifdef BRANCH_STATS_EN
  localparam logic [31:0] EXP_BR = 32'd5;
  localparam logic [31:0] EXP_TK = 32'd3;
`else
  localparam logic [31:0] EXP_BR = 32'd0;
  localparam logic [31:0] EXP_TK = 32'd0;
`endif

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  branch_redirect_ctrl_if #(.ADDR_W(32), .STAT_W(32)) bus ();

  branch_redirect_ctrl #(.ADDR_W(32), .STAT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] ctl_vec();
    return {bus.flush_if, bus.flush_id, bus.redirect_valid, bus.stall_ex, bus.misalign_err};
  endfunction

  // Present one branch for a single sampling edge, return #1 after that edge
  task automatic issue(input logic [1:0] t, input logic z, input logic l,
                       input logic [31:0] pc, input logic [31:0] off, input logic rdy);
    @(negedge clk);
    bus.br_valid       = 1'b1;
    bus.br_type        = t;
    bus.zero           = z;
    bus.lt             = l;
    bus.br_pc          = pc;
    bus.br_offset      = off;
    bus.redirect_ready = rdy;
    @(posedge clk); #1;
    bus.br_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total_cnt++; if (ctl_vec() !== C_IDLE) $display("FAIL reset_ctl: got %b want %b", ctl_vec(), C_IDLE); else pass_cnt++;
    total_cnt++; if (bus.redirect_pc !== 32'h0) $display("FAIL reset_pc: got %h want %h", bus.redirect_pc, 32'h0); else pass_cnt++;
    @(negedge clk); rst = 1'b0;
    issue(JAL, 1'b0, 1'b0, 32'h300, 32'h10, 1'b0);
    total_cnt++; if (ctl_vec() !== C_FL) $display("FAIL rst_pre_flush: got %b want %b", ctl_vec(), C_FL); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (ctl_vec() !== C_RD) $display("FAIL rst_pre_redirect: got %b want %b", ctl_vec(), C_RD); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (ctl_vec() !== C_IDLE) $display("FAIL midreset_ctl: got %b want %b", ctl_vec(), C_IDLE); else pass_cnt++;
    total_cnt++; if (bus.redirect_pc !== 32'h0) $display("FAIL midreset_pc: got %h want %h", bus.redirect_pc, 32'h0); else pass_cnt++;
    total_cnt++; if ({bus.branch_cnt, bus.taken_cnt} !== 64'h0) $display("FAIL midreset_cnt: got %h want %h", {bus.branch_cnt, bus.taken_cnt}, 64'h0); else pass_cnt++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (ctl_vec() !== C_IDLE) $display("FAIL after_reset_ctl: got %b want %b", ctl_vec(), C_IDLE); else pass_cnt++;
  endtask

  task automatic test_beq_taken();
    issue(BEQ, 1'b1, 1'b0, 32'h100, 32'h20, 1'b1);
    total_cnt++; if (ctl_vec() !== C_FL) $display("FAIL beq_flush: got %b want %b", ctl_vec(), C_FL); else pass_cnt++;
    total_cnt++; if (bus.redirect_pc !== 32'h120) $display("FAIL beq_pc: got %h want %h", bus.redirect_pc, 32'h120); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (ctl_vec() !== C_IDLE) $display("FAIL beq_done: got %b want %b", ctl_vec(), C_IDLE); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    issue(JAL, 1'b0, 1'b0, 32'h200, 32'hFFFF_FFF0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (ctl_vec() !== ((i == 0) ? C_FL : C_RD))
        $display("FAIL bp_ctl[%0d]: got %b want %b", i, ctl_vec(), ((i == 0) ? C_FL : C_RD));
      else pass_cnt++;
      total_cnt++; if (bus.redirect_pc !== 32'h1F0) $display("FAIL bp_pc[%0d]: got %h want %h", i, bus.redirect_pc, 32'h1F0); else pass_cnt++;
      if (i == 1) begin
        bus.br_valid  = 1'b1;
        bus.br_type   = BEQ;
        bus.zero      = 1'b1;
        bus.br_pc     = 32'h800;
        bus.br_offset = 32'h40;
      end
      bus.redirect_ready = (i == 3);
      @(posedge clk); #1;
      bus.br_valid = 1'b0;
    end
    bus.redirect_ready = 1'b0;
    total_cnt++; if (ctl_vec() !== C_IDLE) $display("FAIL bp_done: got %b want %b", ctl_vec(), C_IDLE); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (ctl_vec() !== C_IDLE) $display("FAIL bp_ignored_branch: got %b want %b", ctl_vec(), C_IDLE); else pass_cnt++;
    total_cnt++; if (bus.redirect_pc !== 32'h1F0) $display("FAIL bp_pc_hold: got %h want %h", bus.redirect_pc, 32'h1F0); else pass_cnt++;
  endtask

  task automatic test_not_taken();
    issue(BLT, 1'b1, 1'b0, 32'h100, 32'h40, 1'b1);
    total_cnt++; if (ctl_vec() !== C_IDLE) $display("FAIL blt_nt: got %b want %b", ctl_vec(), C_IDLE); else pass_cnt++;
    issue(BEQ, 1'b0, 1'b1, 32'h100, 32'h40, 1'b1);
    total_cnt++; if (ctl_vec() !== C_IDLE) $display("FAIL beq_nt: got %b want %b", ctl_vec(), C_IDLE); else pass_cnt++;
    issue(NJ, 1'b1, 1'b1, 32'h100, 32'h40, 1'b1);
    total_cnt++; if (ctl_vec() !== C_IDLE) $display("FAIL nojump: got %b want %b", ctl_vec(), C_IDLE); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (ctl_vec() !== C_IDLE) $display("FAIL nt_late: got %b want %b", ctl_vec(), C_IDLE); else pass_cnt++;
  endtask

  task automatic test_wrap_misalign();
    issue(BEQ, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h8, 1'b1);
    total_cnt++; if (ctl_vec() !== C_FL) $display("FAIL wrap_flush: got %b want %b", ctl_vec(), C_FL); else pass_cnt++;
    total_cnt++; if (bus.redirect_pc !== 32'h4) $display("FAIL wrap_pc: got %h want %h", bus.redirect_pc, 32'h4); else pass_cnt++;
    @(posedge clk); #1;
    issue(JAL, 1'b0, 1'b0, 32'h100, 32'h6, 1'b1);
    total_cnt++; if (ctl_vec() !== C_MIS) $display("FAIL mis_pulse: got %b want %b", ctl_vec(), C_MIS); else pass_cnt++;
    total_cnt++; if (bus.redirect_pc !== 32'h4) $display("FAIL mis_pc_hold: got %h want %h", bus.redirect_pc, 32'h4); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (ctl_vec() !== C_IDLE) $display("FAIL mis_end: got %b want %b", ctl_vec(), C_IDLE); else pass_cnt++;
  endtask

  task automatic test_stats();
    #2 rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    issue(BEQ, 1'b1, 1'b0, 32'h100, 32'h20, 1'b1);
    @(posedge clk); #1;
    issue(BLT, 1'b0, 1'b0, 32'h100, 32'h20, 1'b1);
    issue(JAL, 1'b0, 1'b0, 32'h400, 32'h8, 1'b0);
    bus.br_valid  = 1'b1;
    bus.br_type   = BEQ;
    bus.zero      = 1'b1;
    bus.br_pc     = 32'h900;
    bus.br_offset = 32'h10;
    @(posedge clk); #1;
    total_cnt++; if (ctl_vec() !== C_RD) $display("FAIL st_redirect: got %b want %b", ctl_vec(), C_RD); else pass_cnt++;
    bus.redirect_ready = 1'b1;
    @(posedge clk); #1;
    bus.br_valid = 1'b0;
    bus.redirect_ready = 1'b0;
    total_cnt++; if (bus.redirect_pc !== 32'h408) $display("FAIL st_pc: got %h want %h", bus.redirect_pc, 32'h408); else pass_cnt++;
    issue(BEQ, 1'b0, 1'b0, 32'h100, 32'h20, 1'b1);
    issue(BLT, 1'b0, 1'b1, 32'h100, 32'h2, 1'b1);
    @(posedge clk); #1;
    issue(NJ, 1'b1, 1'b1, 32'h100, 32'h20, 1'b1);
    total_cnt++; if (bus.branch_cnt !== EXP_BR) $display("FAIL branch_cnt: got %0d want %0d", bus.branch_cnt, EXP_BR); else pass_cnt++;
    total_cnt++; if (bus.taken_cnt !== EXP_TK) $display("FAIL taken_cnt: got %0d want %0d", bus.taken_cnt, EXP_TK); else pass_cnt++;
  endtask

  initial begin
    pass_cnt           = 0;
    total_cnt          = 0;
    rst                = 1'b1;
    bus.br_valid       = 1'b0;
    bus.br_type        = NJ;
    bus.zero           = 1'b0;
    bus.lt             = 1'b0;
    bus.br_pc          = 32'h0;
    bus.br_offset      = 32'h0;
    bus.redirect_ready = 1'b0;
    test_reset();
    test_beq_taken();
    test_backpressure();
    test_not_taken();
    test_wrap_misalign();
    test_stats();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Sequences the control-flow change after the EX stage resolves a branch or jump. It evaluates the branch condition, computes the target, and issues a one-cycle IF/ID flush. It then holds a PC redirect request to the fetch unit until the fetch unit accepts it, and stalls EX while the redirect is outstanding. It sits between the EX-stage branch decode and the fetch PC mux.

Parameters:
ADDR_W, 32, instruction address width (matches instructionAddrPath)
STAT_W, 32, width of statistics counters (used only with the optional feature)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; asynchronous, active-high
br_valid  in  1  EX presents a resolved control-flow instruction this cycle
br_type  in  2  00 NO_JUMP, 01 BEQ, 10 BLT, 11 JAL
zero  in  1  ALU zero flag (rs1==rs2)
lt  in  1  ALU signed less-than flag
br_pc  in  ADDR_W  PC of the branch instruction
br_offset  in  ADDR_W  sign-extended immediate offset
redirect_ready  in  1  fetch accepts redirect this cycle
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  ADDR_W  registered target PC
flush_if  out  1  one-cycle kill of IF/ID register
flush_id  out  1  one-cycle kill of ID/EX register
stall_ex  out  1  hold EX and earlier stages
misalign_err  out  1  one-cycle pulse: taken target not 4-byte aligned
branch_cnt  out  STAT_W  resolved branches (optional feature)
taken_cnt  out  STAT_W  taken branches (optional feature)

Behaviour:
- Reset (async assert): state=IDLE; all outputs 0, including redirect_pc and counters. Reset mid-redirect abandons the request with no flush.
- Taken condition, evaluated in IDLE only:
  - BEQ: zero=1
  - BLT: lt=1
  - JAL: always
  - NO_JUMP: never
- target = br_pc + br_offset, modulo 2^ADDR_W. Carry is discarded, so wrap-around is legal.
- States: IDLE, FLUSH, REDIRECT.
- IDLE:
  - stall_ex=0, redirect_valid=0.
  - If br_valid and taken and target[1:0]==0: latch redirect_pc=target, go to FLUSH.
  - If br_valid and taken and target[1:0]!=0: misalign_err=1 next cycle for exactly 1 cycle, stay in IDLE, no flush, no redirect.
  - Not taken: stay in IDLE, no outputs.
- FLUSH (exactly 1 cycle): flush_if=flush_id=1, redirect_valid=1, stall_ex=1. If redirect_ready=1, go to IDLE; else go to REDIRECT.
- REDIRECT: redirect_valid=1, stall_ex=1, flush outputs 0. redirect_pc is held stable. Go to IDLE on redirect_ready=1.
- Latency: br_valid sampled at edge N gives flush and redirect_valid in cycle N+1. Best case, the controller is back in IDLE at N+2.
- br_valid while not in IDLE is ignored. Upstream is stalled, so this is a protocol violation with no effect.
- redirect_ready while redirect_valid=0 is ignored.
- All outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.

Optional Feature:
BRANCH_STATS_EN:
- Defined: branch_cnt increments when br_valid and br_type!=NO_JUMP are sampled in IDLE. taken_cnt increments when such a branch is also taken, including misaligned ones. Both counters saturate at all-ones and clear on reset.
- Undefined: counters are not instantiated and branch_cnt and taken_cnt are tied to 0.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately, state IDLE.
- BEQ taken: br_type=01, zero=1, br_pc=0x100, br_offset=0x20, redirect_ready=1 -> next cycle flush_if=flush_id=redirect_valid=stall_ex=1, redirect_pc=0x120; following cycle all outputs 0.
- Fetch backpressure: JAL, br_pc=0x200, offset=0xFFFFFFF0, redirect_ready=0 for 3 cycles then 1 -> redirect_pc=0x1F0; redirect_valid high for 4 cycles; flush only in the first cycle; stall_ex high for 4 cycles.
- Not taken: BLT with lt=0, and BEQ with zero=0 -> no flush, no redirect, no stall.
- Wrap and misalign:
  - br_pc=0xFFFFFFFC, offset=8 -> redirect_pc=0x00000004.
  - offset=0x6 from 0x100 -> misalign_err pulses 1 cycle, no redirect.
- Stats (BRANCH_STATS_EN): 5 branches with 3 taken -> branch_cnt=5, taken_cnt=3. br_valid asserted during REDIRECT is not counted.
